// File: rtl/msrv32_branch_redirect_ctrl.sv
// Branch/jump redirect sequencer between execute-stage branch logic and the fetch PC mux.
// Issues a held redirect request with a valid/ready handshake, then kills wrong-path
// instructions for FLUSH_CYCLES cycles. Flags misaligned taken targets, yields to traps
// and keeps evaluated/taken event counters. All outputs are registered.
module msrv32_branch_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             instr_valid_in,
    input  logic [6:0]       opcode_in,
    input  logic             branch_taken_in,
    input  logic [31:0]      target_addr_in,
    input  logic             trap_taken_in,
    input  logic             fetch_ready_in,
    output logic             redirect_valid_out,
    output logic [31:0]      redirect_pc_out,
    output logic             flush_out,
    output logic             stall_out,
    output logic             misaligned_trap_out,
    output logic [CNT_W-1:0] branch_count_out,
    output logic [CNT_W-1:0] taken_count_out
);

    typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

    state_e             state_q, state_d;
    logic [3:0]         kill_q, kill_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               flush_q, flush_d;
    logic               stall_q, stall_d;
    logic               misaligned_q, misaligned_d;
    logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;

    logic               is_cf;
    logic               is_jalr;
    logic [31:0]        eff_target;
    logic               tgt_misaligned;
    logic               eval_cf;
    logic               take_redirect;
    logic               unused_opcode_lsb;

    // Opcode low bits are always 2'b11 for 32-bit instructions and carry no class info.
    assign unused_opcode_lsb = ^opcode_in[1:0];

    // Decode the execute-stage instruction and qualify it against state and trap.
    always_comb begin
        is_jalr        = (opcode_in[6:2] == 5'b11001);
        is_cf          = instr_valid_in &&
                         ((opcode_in[6:2] == 5'b11000) ||
                          (opcode_in[6:2] == 5'b11011) || is_jalr);
        eff_target     = is_jalr ? {target_addr_in[31:1], 1'b0} : target_addr_in;
        tgt_misaligned = (eff_target[1:0] != 2'b00);
        // Only an IDLE cycle without a competing trap evaluates control flow.
        eval_cf        = is_cf && !trap_taken_in && (state_q == StIdle);
        take_redirect  = eval_cf && branch_taken_in && !tgt_misaligned;
    end

    // State, kill counter, registered outputs and counters; synchronous active-low reset.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q          <= StIdle;
            kill_q           <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            misaligned_q     <= 1'b0;
            branch_cnt_q     <= '0;
            taken_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            kill_q           <= kill_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            stall_q          <= stall_d;
            misaligned_q     <= misaligned_d;
            branch_cnt_q     <= branch_cnt_d;
            taken_cnt_q      <= taken_cnt_d;
        end
    end

    // Next-state: trap wins, then the redirect handshake and the fixed-length kill window.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        if (trap_taken_in) begin
            state_d = StIdle;
            kill_d  = 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (take_redirect) state_d = StRedirect;
                end
                StRedirect: begin
                    if (fetch_ready_in) begin
                        state_d = StFlush;
                        kill_d  = 4'(FLUSH_CYCLES);
                    end
                end
                StFlush: begin
                    // kill_q counts the FLUSH cycles still to be shown including this one.
                    if (kill_q <= 4'd1) begin
                        state_d = StIdle;
                        kill_d  = 4'd0;
                    end else begin
                        kill_d = kill_q - 4'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    kill_d  = 4'd0;
                end
            endcase
        end
    end

    // Output next-values derive from the upcoming state so every output is a flop.
    always_comb begin
        redirect_valid_d = (state_d == StRedirect);
        stall_d          = (state_d == StRedirect);
        flush_d          = (state_d == StRedirect) || (state_d == StFlush);
        misaligned_d     = eval_cf && branch_taken_in && tgt_misaligned;
        redirect_pc_d    = take_redirect ? eff_target : redirect_pc_q;
        branch_cnt_d     = eval_cf ? branch_cnt_q + CNT_W'(1) : branch_cnt_q;
        taken_cnt_d      = take_redirect ? taken_cnt_q + CNT_W'(1) : taken_cnt_q;
    end

    assign redirect_valid_out  = redirect_valid_q;
    assign redirect_pc_out     = redirect_pc_q;
    assign flush_out           = flush_q;
    assign stall_out           = stall_q;
    assign misaligned_trap_out = misaligned_q;
    assign branch_count_out    = branch_cnt_q;
    assign taken_count_out     = taken_cnt_q;

endmodule

// File: tb/tb_msrv32_branch_redirect_ctrl.sv
// Self-checking bench: directed scenarios plus randomized instructions checked against a
// transaction-level model of the redirect sequence. A second instance with 4-bit counters
// makes counter wrap reachable in a short run.
module tb_msrv32_branch_redirect_ctrl;

    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [6:0]  opcode;
    logic        taken;
    logic [31:0] target;
    logic        trap;
    logic        fetch_ready;

    logic        redirect_valid, flush, stall, mis;
    logic [31:0] redirect_pc;
    logic [15:0] br_cnt, tk_cnt;
    logic        s_rv, s_fl, s_st, s_mis;
    logic [31:0] s_pc;
    logic [3:0]  s_br, s_tk;
    logic [3:0]  ctl;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_br = 0;
    int exp_tk = 0;

    assign ctl = {redirect_valid, flush, stall, mis};

    always #5 clk = ~clk;

    msrv32_branch_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .instr_valid_in       (instr_valid),
        .opcode_in            (opcode),
        .branch_taken_in      (taken),
        .target_addr_in       (target),
        .trap_taken_in        (trap),
        .fetch_ready_in       (fetch_ready),
        .redirect_valid_out   (redirect_valid),
        .redirect_pc_out      (redirect_pc),
        .flush_out            (flush),
        .stall_out            (stall),
        .misaligned_trap_out  (mis),
        .branch_count_out     (br_cnt),
        .taken_count_out      (tk_cnt)
    );

    msrv32_branch_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut_s (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .instr_valid_in       (instr_valid),
        .opcode_in            (opcode),
        .branch_taken_in      (taken),
        .target_addr_in       (target),
        .trap_taken_in        (trap),
        .fetch_ready_in       (fetch_ready),
        .redirect_valid_out   (s_rv),
        .redirect_pc_out      (s_pc),
        .flush_out            (s_fl),
        .stall_out            (s_st),
        .misaligned_trap_out  (s_mis),
        .branch_count_out     (s_br),
        .taken_count_out      (s_tk)
    );

    function automatic logic is_cf(input logic [6:0] op);
        return (op[6:2] == 5'b11000) || (op[6:2] == 5'b11011) || (op[6:2] == 5'b11001);
    endfunction

    function automatic logic [31:0] eff(input logic [6:0] op, input logic [31:0] tgt);
        logic [31:0] t;
        t = tgt;
        if (op[6:2] == 5'b11001) t[0] = 1'b0;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wrong-path traffic: must be ignored while redirecting or flushing.
    task automatic junk();
        instr_valid = 1'($urandom % 2);
        opcode      = 7'($urandom);
        taken       = 1'($urandom);
        target      = $urandom;
    endtask

    // One instruction presented in IDLE; checks the whole resulting output sequence.
    task automatic run_instr(input logic [6:0] op, input logic tk, input logic [31:0] tgt,
                             input int delay);
        logic [31:0] e;
        logic        cf;
        e  = eff(op, tgt);
        cf = is_cf(op);
        instr_valid = 1'b1; opcode = op; taken = tk; target = tgt; trap = 1'b0;
        fetch_ready = 1'($urandom);
        step();
        if (cf) exp_br++;
        if (cf && tk && (e[1:0] != 2'b00)) begin
            n_cmp++;
            if (ctl !== 4'b0001) begin
                n_fail++; $display("FAIL misaligned_pulse: got %b want 0001", ctl);
            end
            instr_valid = 1'b0;
            step();
            n_cmp++;
            if (ctl !== 4'b0000) begin
                n_fail++; $display("FAIL misaligned_one_cycle: got %b want 0000", ctl);
            end
        end else if (cf && tk) begin
            exp_tk++;
            n_cmp++;
            if (ctl !== 4'b1110 || redirect_pc !== e) begin
                n_fail++;
                $display("FAIL redirect_start: got %b pc %h want 1110 pc %h", ctl, redirect_pc, e);
            end
            for (int k = 0; k < delay; k++) begin
                junk(); fetch_ready = 1'b0;
                step();
                n_cmp++;
                if (ctl !== 4'b1110 || redirect_pc !== e) begin
                    n_fail++;
                    $display("FAIL redirect_hold: got %b pc %h want 1110 pc %h", ctl, redirect_pc, e);
                end
            end
            junk(); fetch_ready = 1'b1;
            step();
            n_cmp++;
            if (ctl !== 4'b0100) begin
                n_fail++; $display("FAIL flush_entry: got %b want 0100", ctl);
            end
            for (int k = 0; k < int'(FC) - 1; k++) begin
                junk(); fetch_ready = 1'($urandom);
                step();
                n_cmp++;
                if (ctl !== 4'b0100) begin
                    n_fail++; $display("FAIL flush_hold: got %b want 0100", ctl);
                end
            end
            junk();
            step();
            n_cmp++;
            if (ctl !== 4'b0000) begin
                n_fail++; $display("FAIL flush_exit: got %b want 0000", ctl);
            end
        end else begin
            n_cmp++;
            if (ctl !== 4'b0000) begin
                n_fail++; $display("FAIL no_redirect: got %b want 0000", ctl);
            end
        end
        instr_valid = 1'b0;
        n_cmp++;
        if ({br_cnt, tk_cnt, s_br, s_tk} !==
            {exp_br[15:0], exp_tk[15:0], exp_br[3:0], exp_tk[3:0]}) begin
            n_fail++;
            $display("FAIL counters: got %h/%h small %h/%h want %h/%h", br_cnt, tk_cnt, s_br, s_tk,
                     exp_br[15:0], exp_tk[15:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; instr_valid = 1'b0; opcode = 7'd0; taken = 1'b0; target = 32'd0;
        trap = 1'b0; fetch_ready = 1'b0;
        step(); step();
        rst = 1'b1;
        exp_br = 0; exp_tk = 0;
        n_cmp++;
        if (ctl !== 4'b0000 || redirect_pc !== 32'd0 || br_cnt !== 16'd0 || tk_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b pc %h cnt %h/%h want all zero", ctl, redirect_pc,
                     br_cnt, tk_cnt);
        end
    endtask

    task automatic test_beq_ready();
        run_instr(7'b1100011, 1'b1, 32'h0000_0100, 0);
    endtask

    task automatic test_jalr_backpressure();
        run_instr(7'b1100111, 1'b1, 32'h0000_2001, 4);
    endtask

    task automatic test_misaligned_jal();
        run_instr(7'b1101111, 1'b1, 32'h0000_0102, 0);
        run_instr(7'b1100011, 1'b1, 32'h0000_0201, 0);
    endtask

    task automatic test_not_taken();
        run_instr(7'b1100011, 1'b0, 32'h0000_0300, 0);
        run_instr(7'b0110011, 1'b1, 32'h0000_0400, 0);
        run_instr(7'b0000011, 1'b1, 32'h0000_0401, 0);
    endtask

    task automatic test_trap();
        // Taken branch and trap together: branch is discarded.
        instr_valid = 1'b1; opcode = 7'b1100011; taken = 1'b1; target = 32'h0000_0800;
        trap = 1'b1;
        step();
        n_cmp++;
        if (ctl !== 4'b0000) begin
            n_fail++; $display("FAIL trap_same_cycle: got %b want 0000", ctl);
        end
        // Misaligned JAL with trap: no pulse.
        opcode = 7'b1101111; target = 32'h0000_0802;
        step();
        n_cmp++;
        if (ctl !== 4'b0000) begin
            n_fail++; $display("FAIL trap_misaligned: got %b want 0000", ctl);
        end
        trap = 1'b0; instr_valid = 1'b0;
        step();
        n_cmp++;
        if (ctl !== 4'b0000 || br_cnt !== exp_br[15:0] || tk_cnt !== exp_tk[15:0]) begin
            n_fail++;
            $display("FAIL trap_counters: got %b %h/%h want 0000 %h/%h", ctl, br_cnt, tk_cnt,
                     exp_br[15:0], exp_tk[15:0]);
        end
        // Trap during REDIRECT.
        instr_valid = 1'b1; opcode = 7'b1100011; taken = 1'b1; target = 32'h0000_0400;
        step();
        exp_br++; exp_tk++;
        junk(); fetch_ready = 1'b0; trap = 1'b1;
        step();
        n_cmp++;
        if (ctl !== 4'b0000) begin
            n_fail++; $display("FAIL trap_in_redirect: got %b want 0000", ctl);
        end
        // Trap during FLUSH.
        trap = 1'b0;
        instr_valid = 1'b1; opcode = 7'b1101111; taken = 1'b1; target = 32'h0000_0500;
        step();
        exp_br++; exp_tk++;
        junk(); fetch_ready = 1'b1;
        step();
        junk(); trap = 1'b1;
        step();
        n_cmp++;
        if (ctl !== 4'b0000) begin
            n_fail++; $display("FAIL trap_in_flush: got %b want 0000", ctl);
        end
        trap = 1'b0; instr_valid = 1'b0;
        step();
        n_cmp++;
        if (ctl !== 4'b0000 || redirect_pc !== 32'h0000_0500 || br_cnt !== exp_br[15:0] ||
            tk_cnt !== exp_tk[15:0]) begin
            n_fail++;
            $display("FAIL trap_recover: got %b pc %h %h/%h want 0000 pc 00000500 %h/%h", ctl,
                     redirect_pc, br_cnt, tk_cnt, exp_br[15:0], exp_tk[15:0]);
        end
    endtask

    task automatic test_reset_mid_flush();
        instr_valid = 1'b1; opcode = 7'b1100011; taken = 1'b1; target = 32'h0000_0900;
        trap = 1'b0;
        step();
        junk(); fetch_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1; instr_valid = 1'b0;
        exp_br = 0; exp_tk = 0;
        n_cmp++;
        if (ctl !== 4'b0000 || redirect_pc !== 32'd0 || br_cnt !== 16'd0 || tk_cnt !== 16'd0 ||
            s_br !== 4'd0 || s_tk !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_flush: got %b pc %h cnt %h/%h want all zero", ctl,
                     redirect_pc, br_cnt, tk_cnt);
        end
        step();
        n_cmp++;
        if (ctl !== 4'b0000) begin
            n_fail++; $display("FAIL reset_stays_idle: got %b want 0000", ctl);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 15; i++) run_instr(7'b1100011, 1'b1, 32'h0000_1000 + 32'(i * 4), 0);
        n_cmp++;
        if (s_tk !== 4'hF) begin
            n_fail++; $display("FAIL wrap_at_max: got %h want f", s_tk);
        end
        run_instr(7'b1101111, 1'b1, 32'h0000_2000, 0);
        n_cmp++;
        if (s_tk !== 4'h0 || s_br !== 4'h0 || tk_cnt !== 16'd16) begin
            n_fail++;
            $display("FAIL wrap_to_zero: got small %h/%h big %h want 0/0 big 0010", s_br, s_tk,
                     tk_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run_instr(7'b1100011, 1'b1, 32'h0000_3000, 0);
        run_instr(7'b1100111, 1'b1, 32'h0000_3103, 1);
        run_instr(7'b1101111, 1'b1, 32'h0000_3200, 2);
    endtask

    task automatic test_random();
        logic [6:0]  op;
        logic [31:0] tgt;
        for (int i = 0; i < 60; i++) begin
            case ($urandom % 5)
                0:       op = 7'b1100011;
                1:       op = 7'b1101111;
                2:       op = 7'b1100111;
                3:       op = 7'b0110011;
                default: op = 7'($urandom);
            endcase
            tgt = $urandom;
            if ($urandom % 2 == 0) tgt[1:0] = 2'b00;
            run_instr(op, 1'($urandom), tgt, int'($urandom % 4));
        end
    endtask

    initial begin
        test_reset();
        test_beq_ready();
        test_jalr_backpressure();
        test_misaligned_jal();
        test_not_taken();
        test_trap();
        test_back_to_back();
        test_reset_mid_flush();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/msrv32_branch_redirect_ctrl.md
Name: msrv32_branch_redirect_ctrl

Overview:
Sequences the control-flow redirect that follows a branch/jump decision. Watches decoded instruction class and the taken decision from the branch unit. Issues a held PC-redirect request to fetch with a valid/ready handshake, then kills wrong-path instructions for a fixed number of cycles. Also flags misaligned targets, yields to traps, and keeps branch/taken event counters. Sits between the execute-stage branch logic and the fetch/PC mux.

Parameters:
FLUSH_CYCLES, 2, wrong-path kill cycles after redirect acceptance; legal range 1..15.
CNT_W, 16, width of the event counters.

Ports:
ms_riscv32_mp_clk_in  input  1  core clock; all state on rising edge.
ms_riscv32_mp_rst_in  input  1  synchronous, active-low reset.
instr_valid_in  input  1  execute-stage instruction is valid this cycle.
opcode_in  input  7  opcode of the execute-stage instruction.
branch_taken_in  input  1  taken decision from the branch unit; 1 for JAL/JALR.
target_addr_in  input  32  computed branch/jump target.
trap_taken_in  input  1  trap/interrupt redirect from machine control; highest priority.
fetch_ready_in  input  1  fetch accepts the redirect this cycle.
redirect_valid_out  output  1  redirect request pending.
redirect_pc_out  output  32  redirect target; stable while redirect_valid_out=1.
flush_out  output  1  kill the decode/execute instruction this cycle.
stall_out  output  1  hold the decode stage.
misaligned_trap_out  output  1  one-cycle pulse: taken target not word-aligned.
branch_count_out  output  CNT_W  count of evaluated control-flow instructions.
taken_count_out  output  CNT_W  count of redirects issued.

Behaviour:
- Control-flow class: opcode_in[6:2] equal to 11000 (BRANCH), 11011 (JAL) or 11001 (JALR). Any other opcode is ignored.
- Effective target: target_addr_in with bit 0 forced to 0 for JALR, otherwise unchanged.
- All outputs are registered. FSM states: IDLE, REDIRECT, FLUSH.
- Reset (rst_in=0 at a clock edge): state goes to IDLE. All outputs go to 0, including redirect_pc_out and both counters. Reset overrides every other input, including mid-REDIRECT and mid-FLUSH.
- Trap: trap_taken_in=1 in any state forces IDLE at the next edge.
  - redirect_valid_out, flush_out and stall_out become 0; the flush counter is cleared.
  - No counter increments. A branch presented in the same cycle is discarded, with no redirect and no misaligned pulse.
- IDLE, with instr_valid_in=1 and a control-flow instruction:
  - branch_count_out increments by 1 (wraps at 2^CNT_W).
  - Not taken: stay in IDLE, no other effect.
  - Taken with effective target[1:0]!=00: misaligned_trap_out=1 for exactly one cycle after the edge. No redirect; stay in IDLE; taken_count_out unchanged.
  - Taken and aligned: redirect_pc_out is loaded with the effective target; taken_count_out increments (wraps); next state is REDIRECT.
  - Latency: redirect_valid_out=1 on the cycle after the sampling edge.
- REDIRECT:
  - redirect_valid_out=1, flush_out=1, stall_out=1; redirect_pc_out is held.
  - instr_valid_in is ignored (wrong path); no counter changes.
  - fetch_ready_in=0: remain in REDIRECT indefinitely.
  - fetch_ready_in=1: the handshake completes at that edge. Next state is FLUSH, the kill counter loads FLUSH_CYCLES, and redirect_valid_out drops to 0.
- FLUSH:
  - flush_out=1, stall_out=0, redirect_valid_out=0; instr_valid_in is ignored.
  - The kill counter decrements each cycle. flush_out stays high for exactly FLUSH_CYCLES cycles, then the state returns to IDLE.
  - A control-flow instruction on the first IDLE cycle after FLUSH is evaluated normally (back-to-back branches are supported).
- stall_out=1 only in REDIRECT.
- misaligned_trap_out is never asserted in REDIRECT or FLUSH.
- Counter wrap: at value 2^CNT_W-1, a further increment yields 0.

Test Plan:
1. BEQ (opcode 1100011), taken=1, target 0x0000_0100, fetch_ready=1 tied -> redirect_valid=1 for 1 cycle with redirect_pc=0x100; flush_out=1 for 1+2 cycles; branch_count=1, taken_count=1.
2. JALR (opcode 1100111), target 0x0000_2001, fetch_ready=0 for 4 cycles then 1 -> redirect_pc=0x2000 held stable for 5 cycles with stall_out=1; no misaligned pulse; 2 FLUSH cycles follow.
3. JAL, target 0x0000_0102 -> misaligned_trap_out pulses for 1 cycle; redirect_valid stays 0; branch_count=1, taken_count=0.
4. BNE not taken, then an ADD (0110011) with taken=1 -> branch_count=1, taken_count=0, no redirect and no flush.
5. Taken branch and trap_taken_in=1 in the same cycle -> no redirect, counters unchanged. Separately, assert trap during REDIRECT -> next cycle IDLE with all control outputs 0.
6. Reset low mid-FLUSH, and counters preset to 0xFFFF then one more taken branch -> after reset all outputs 0; the wrap case yields taken_count=0x0000.
